hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, branch flush,
// ID/EX..MEM/WB control/rd shadow registers, operand forwarding and a stall counter.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] id_ctrl,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_branch_taken,
  output logic       stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic [5:0] ex_ctrl,
  output logic [3:0] mem_ctrl,
  output logic [1:0] wb_ctrl,
  output logic [4:0] ex_rd,
  output logic [4:0] mem_rd,
  output logic [4:0] wb_rd,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [15:0] stall_count
);

  localparam int unsigned CTRL_W = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [1:0]       FWD_RF   = 2'b00;
  localparam logic [1:0]       FWD_MEM  = 2'b10;
  localparam logic [1:0]       FWD_WB   = 2'b01;

  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [REG_W-1:0]  ex_rd_q,    ex_rd_d;
  logic [REG_W-1:0]  ex_rs1_q,   ex_rs1_d;
  logic [REG_W-1:0]  ex_rs2_q,   ex_rs2_d;
  logic [3:0]        mem_ctrl_q, mem_ctrl_d;
  logic [REG_W-1:0]  mem_rd_q,   mem_rd_d;
  logic [1:0]        wb_ctrl_q,  wb_ctrl_d;
  logic [REG_W-1:0]  wb_rd_q,    wb_rd_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic take;
  logic load_use;
  logic stall_int;

  // Taken branch only counts when the EX instruction really is a branch.
  assign take      = ex_branch_taken & ex_ctrl_q[0];
  assign load_use  = ex_ctrl_q[2] && (ex_rd_q != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd_q)) ||
                      (id_rs2_used && (id_rs2 == ex_rd_q)));
  assign stall_int = load_use & ~take;

  // EX/MEM wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic             mem_wr,
    input logic [REG_W-1:0] m_rd,
    input logic             wb_wr,
    input logic [REG_W-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_wr && (m_rd != '0) && (m_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (w_rd != '0) && (w_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    ex_ctrl_d     = id_ctrl;
    ex_rd_d       = id_rd;
    ex_rs1_d      = id_rs1_used ? id_rs1 : '0;
    ex_rs2_d      = id_rs2_used ? id_rs2 : '0;
    mem_ctrl_d    = ex_ctrl_q[4:1];
    mem_rd_d      = ex_rd_q;
    wb_ctrl_d     = mem_ctrl_q[3:2];
    wb_rd_d       = mem_rd_q;
    stall_count_d = stall_count_q;
    // Explicit bubble: decoder control bits are not trusted to be zero.
    if (stall_int || take) begin
      ex_ctrl_d = '0;
      ex_rd_d   = '0;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
    end
    if (stall_int && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q     <= '0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      mem_ctrl_q    <= '0;
      mem_rd_q      <= '0;
      wb_ctrl_q     <= '0;
      wb_rd_q       <= '0;
      stall_count_q <= '0;
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_rd_q      <= mem_rd_d;
      wb_ctrl_q     <= wb_ctrl_d;
      wb_rd_q       <= wb_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall       = stall_int;
  assign pc_we       = ~stall_int;
  assign ifid_we     = ~stall_int;
  assign ifid_flush  = take;
  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign ex_rd       = ex_rd_q;
  assign mem_rd      = mem_rd_q;
  assign wb_rd       = wb_rd_q;
  assign stall_count = stall_count_q;
  assign fwd_a = fwd_sel(ex_rs1_q, mem_ctrl_q[2], mem_rd_q, wb_ctrl_q[0], wb_rd_q);
  assign fwd_b = fwd_sel(ex_rs2_q, mem_ctrl_q[2], mem_rd_q, wb_ctrl_q[0], wb_rd_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] ALU = 6'b001000;
  localparam logic [5:0] LW  = 6'b111100;
  localparam logic [5:0] LWB = 6'b111101;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       ex_branch_taken;
  logic       stall, pc_we, ifid_we, ifid_flush;
  logic [5:0] ex_ctrl;
  logic [3:0] mem_ctrl;
  logic [1:0] wb_ctrl;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_branch_taken(ex_branch_taken),
    .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] c, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd);
    id_ctrl = c; id_rs1 = r1; id_rs1_used = u1;
    id_rs2 = r2; id_rs2_used = u2; id_rd = rd;
    #1;
  endtask

  // Advance one edge; return 1 time unit after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_branch_taken = 1'b0;
    set_id(NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_stall",  16'(stall), 16'd0);
    check("rst_pc_we",  16'(pc_we), 16'd1);
    check("rst_ifid_we", 16'(ifid_we), 16'd1);
    check("rst_flush",  16'(ifid_flush), 16'd0);
    check("rst_fwd_a",  16'(fwd_a), 16'd0);
    check("rst_fwd_b",  16'(fwd_b), 16'd0);
    check("rst_count",  stall_count, 16'd0);
    check("rst_ex_ctrl", 16'(ex_ctrl), 16'd0);

    // Load-use: lw x5 then use of x5
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    check("lu_no_stall_first", 16'(stall), 16'd0);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    check("lu_stall", 16'(stall), 16'd1);
    check("lu_pc_we", 16'(pc_we), 16'd0);
    check("lu_ifid_we", 16'(ifid_we), 16'd0);
    tick();
    check("lu_stall_drop", 16'(stall), 16'd0);
    check("lu_bubble_ctrl", 16'(ex_ctrl), 16'd0);
    check("lu_bubble_rd", 16'(ex_rd), 16'd0);
    check("lu_count", stall_count, 16'd1);
    check("lu_mem_ctrl", 16'(mem_ctrl), 16'h000E);
    check("lu_mem_rd", 16'(mem_rd), 16'd5);
    tick();
    set_id(NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("lu_ex_ctrl", 16'(ex_ctrl), 16'(ALU));
    check("lu_wb_ctrl", 16'(wb_ctrl), 16'h0003);
    check("lu_fwd_wb", 16'(fwd_a), 16'h0001);
    tick();

    // Forwarding from EX/MEM
    set_id(ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7);
    tick();
    set_id(ALU, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8);
    tick();
    check("fw_mem_ctrl", 16'(mem_ctrl), 16'h0004);
    check("fw_mem_rd", 16'(mem_rd), 16'd7);
    check("fw_a_mem", 16'(fwd_a), 16'h0002);
    // Forwarding from MEM/WB with one unrelated instruction between
    set_id(ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7);
    tick();
    set_id(ALU, 5'd2, 1'b1, 5'd0, 1'b0, 5'd10);
    tick();
    set_id(ALU, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8);
    tick();
    check("fw_a_wb", 16'(fwd_a), 16'h0001);

    // x0 never stalls or forwards
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    set_id(ALU, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6);
    check("x0_stall", 16'(stall), 16'd0);
    tick();
    check("x0_fwd_a", 16'(fwd_a), 16'd0);
    check("x0_fwd_b", 16'(fwd_b), 16'd0);
    check("x0_count", stall_count, 16'd1);

    // EX/MEM priority over MEM/WB on rs2
    set_id(ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9);
    tick();
    set_id(ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9);
    tick();
    set_id(ALU, 5'd3, 1'b1, 5'd9, 1'b1, 5'd11);
    tick();
    check("prio_fwd_b", 16'(fwd_b), 16'h0002);
    check("prio_fwd_a", 16'(fwd_a), 16'd0);
    // Unused rs2 must not forward even though its index matches
    set_id(ALU, 5'd0, 1'b0, 5'd9, 1'b0, 5'd12);
    tick();
    check("gate_fwd_b", 16'(fwd_b), 16'd0);

    // Taken branch beats load-use
    set_id(LWB, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    ex_branch_taken = 1'b1;
    #1;
    check("br_flush", 16'(ifid_flush), 16'd1);
    check("br_stall", 16'(stall), 16'd0);
    check("br_pc_we", 16'(pc_we), 16'd1);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    check("br_bubble_ctrl", 16'(ex_ctrl), 16'd0);
    check("br_bubble_rd", 16'(ex_rd), 16'd0);
    check("br_count", stall_count, 16'd1);
    check("br_mem_ctrl", 16'(mem_ctrl), 16'h000E);
    // Taken flag on a non-branch is ignored
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    ex_branch_taken = 1'b1;
    #1;
    check("nb_flush", 16'(ifid_flush), 16'd0);
    check("nb_stall", 16'(stall), 16'd1);
    tick();
    ex_branch_taken = 1'b0;
    set_id(NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("nb_count", stall_count, 16'd2);
    tick();

    // Saturation: preload near the top, then stall twice
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    check("sat_stall1", 16'(stall), 16'd1);
    tick();
    check("sat_max", stall_count, 16'hFFFF);
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    check("sat_stall2", 16'(stall), 16'd1);
    tick();
    check("sat_hold", stall_count, 16'hFFFF);

    // Reset in the middle of a stall
    set_id(LW, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    check("mr_stall", 16'(stall), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_id(NOP, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    check("mr_stall_after", 16'(stall), 16'd0);
    check("mr_pc_we", 16'(pc_we), 16'd1);
    check("mr_ifid_we", 16'(ifid_we), 16'd1);
    check("mr_flush", 16'(ifid_flush), 16'd0);
    check("mr_fwd_a", 16'(fwd_a), 16'd0);
    check("mr_fwd_b", 16'(fwd_b), 16'd0);
    check("mr_count", stall_count, 16'd0);
    check("mr_ex_ctrl", 16'(ex_ctrl), 16'd0);
    check("mr_mem_ctrl", 16'(mem_ctrl), 16'd0);
    check("mr_wb_ctrl", 16'(wb_ctrl), 16'd0);
    check("mr_wb_rd", 16'(wb_rd), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
